// File: rtl/nios2_oci_ram_arbiter.sv
// nios2_oci_ram_arbiter
//   Shares the single-port on-chip debug RAM between the JTAG debug path and the CPU-side
//   Avalon debug slave. Round-robin arbitration with one access in flight at a time.
//
// Ports
//   clk, reset_n        system clock (rising edge), asynchronous active-low reset
//   jtag_req/wr/addr/wdata   1-cycle JTAG command strobe and its payload
//   jtag_rdata          last JTAG read result, held until the next JTAG read completes
//   jtag_done           1-cycle pulse when a JTAG access completes
//   jtag_overrun        sticky flag: strobe arrived while a JTAG command was pending
//   overrun_clr         clears jtag_overrun (a simultaneous set takes priority)
//   av_*                Avalon-MM slave (read/write held until av_waitrequest is low)
//   ram_en/we/addr/wdata, ram_rdata   debug RAM port, read data one cycle after ram_en
module nios2_oci_ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,
    input  logic              overrun_clr,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

    state_e            state_q, state_d;
    logic              last_jtag_q, last_jtag_d;  // 0 = Avalon had the last grant
    logic              gnt_jtag_q, gnt_jtag_d;
    logic              acc_we_q, acc_we_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;

    logic              pend_q, pend_d;
    logic              hold_wr_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_wdata_q;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_done_q;

    logic              av_live, jtag_live, pick_jtag;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              in_access, in_capture;
    logic              jtag_wr_done, jtag_rd_done, jtag_complete;
    logic              av_wr_done, av_rd_done;
    logic              jtag_accept;

    assign av_live   = av_read | av_write;
    // A fresh strobe is granted directly from the inputs so an idle arbiter adds no cycle.
    assign jtag_live = pend_q | jtag_req;
    assign cmd_wr    = pend_q ? hold_wr_q    : jtag_wr;
    assign cmd_addr  = pend_q ? hold_addr_q  : jtag_addr;
    assign cmd_wdata = pend_q ? hold_wdata_q : jtag_wdata;

    assign in_access  = (state_q == StAccess);
    assign in_capture = (state_q == StCapture);

    assign jtag_wr_done  = in_access  &  gnt_jtag_q &  acc_we_q;
    assign jtag_rd_done  = in_capture &  gnt_jtag_q & ~acc_we_q;
    assign av_wr_done    = in_access  & ~gnt_jtag_q &  acc_we_q;
    assign av_rd_done    = in_capture & ~gnt_jtag_q & ~acc_we_q;
    assign jtag_complete = jtag_wr_done | jtag_rd_done;

    // A strobe landing in the completion cycle of the pending command replaces it.
    assign jtag_accept = jtag_req & (~pend_q | jtag_complete);

    always_comb begin
        pend_d = pend_q;
        if (jtag_accept) begin
            pend_d = 1'b1;
        end else if (jtag_complete) begin
            pend_d = 1'b0;
        end
        overrun_d = (jtag_req & ~jtag_accept) | (overrun_q & ~overrun_clr);
    end

    always_comb begin
        state_d     = state_q;
        last_jtag_d = last_jtag_q;
        gnt_jtag_d  = gnt_jtag_q;
        acc_we_d    = acc_we_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        pick_jtag   = jtag_live & (~av_live | ~last_jtag_q);
        unique case (state_q)
            StIdle: begin
                if (jtag_live | av_live) begin
                    state_d     = StAccess;
                    last_jtag_d = pick_jtag;
                    gnt_jtag_d  = pick_jtag;
                    if (pick_jtag) begin
                        acc_we_d    = cmd_wr;
                        acc_addr_d  = cmd_addr;
                        acc_wdata_d = cmd_wdata;
                    end else begin
                        // Read and write together is treated as a write.
                        acc_we_d    = av_write;
                        acc_addr_d  = av_address;
                        acc_wdata_d = av_writedata;
                    end
                end
            end
            StAccess:  state_d = acc_we_q ? StIdle : StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_jtag_q  <= 1'b0;
            gnt_jtag_q   <= 1'b0;
            acc_we_q     <= 1'b0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            pend_q       <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            overrun_q    <= 1'b0;
            rdata_q      <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_jtag_q <= last_jtag_d;
            gnt_jtag_q  <= gnt_jtag_d;
            acc_we_q    <= acc_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            rd_done_q   <= jtag_rd_done;
            if (jtag_accept) begin
                hold_wr_q    <= jtag_wr;
                hold_addr_q  <= jtag_addr;
                hold_wdata_q <= jtag_wdata;
            end
            if (jtag_rd_done) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    assign jtag_rdata     = rdata_q;
    assign jtag_done      = jtag_wr_done | rd_done_q;
    assign jtag_overrun   = overrun_q;
    assign av_readdata    = av_rd_done ? ram_rdata : '0;
    assign av_waitrequest = av_live & ~(av_wr_done | av_rd_done);
    assign ram_en         = in_access;
    assign ram_we         = in_access & acc_we_q;
    assign ram_addr       = acc_addr_q;
    assign ram_wdata      = acc_wdata_q;

endmodule

// File: tb/tb_nios2_oci_ram_arbiter.sv
// Directed bench for nios2_oci_ram_arbiter with a behavioural single-port RAM.
module tb_nios2_oci_ram_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              jtag_req, jtag_wr;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata, jtag_rdata;
    logic              jtag_done, jtag_overrun, overrun_clr;
    logic              av_read, av_write;
    logic [ADDR_W-1:0] av_address;
    logic [DATA_W-1:0] av_writedata, av_readdata;
    logic              av_waitrequest;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int en_cnt   = 0;

    always #5 clk = ~clk;

    nios2_oci_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .jtag_req      (jtag_req),
        .jtag_wr       (jtag_wr),
        .jtag_addr     (jtag_addr),
        .jtag_wdata    (jtag_wdata),
        .jtag_rdata    (jtag_rdata),
        .jtag_done     (jtag_done),
        .jtag_overrun  (jtag_overrun),
        .overrun_clr   (overrun_clr),
        .av_read       (av_read),
        .av_write      (av_write),
        .av_address    (av_address),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .av_waitrequest(av_waitrequest),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    // Behavioural RAM: write on ram_en&ram_we, registered read otherwise.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (jtag_done)        done_cnt <= done_cnt + 1;
        if (ram_en && ram_we) wr_cnt   <= wr_cnt + 1;
        if (ram_en)           en_cnt   <= en_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int lowk, jdk, d0, w0, e0, n_acc, prev_src, src, b2b, j_idx, a_idx;
        logic prev_en, rearm, av_adv, timeout;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset_n = 1'b0;
        jtag_req = 1'b0; jtag_wr = 1'b0; jtag_addr = '0; jtag_wdata = '0;
        overrun_clr = 1'b0;
        av_read = 1'b0; av_write = 1'b0; av_address = '0; av_writedata = '0;

        // Reset state
        #12;
        check_eq("rst_ram_en", 64'(ram_en), 64'd0);
        check_eq("rst_jtag_done", 64'(jtag_done), 64'd0);
        check_eq("rst_rdata", 64'(jtag_rdata), 64'd0);
        check_eq("rst_waitreq", 64'(av_waitrequest), 64'd0);
        check_eq("rst_overrun", 64'(jtag_overrun), 64'd0);
        cyc(); reset_n = 1'b1;

        // T1: JTAG write then read
        cyc(); jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h10; jtag_wdata = 32'hDEADBEEF;
        smp(); check_eq("t1_idle_en", 64'(ram_en), 64'd0);
        cyc(); jtag_req = 1'b0;
        smp();
        check_eq("t1_wr_en", 64'(ram_en), 64'd1);
        check_eq("t1_wr_we", 64'(ram_we), 64'd1);
        check_eq("t1_wr_addr", 64'(ram_addr), 64'h10);
        check_eq("t1_wr_data", 64'(ram_wdata), 64'hDEADBEEF);
        check_eq("t1_wr_done", 64'(jtag_done), 64'd1);
        cyc(); smp();
        check_eq("t1_wr_done_drop", 64'(jtag_done), 64'd0);
        cyc(); jtag_req = 1'b1; jtag_wr = 1'b0; smp();
        cyc(); jtag_req = 1'b0; smp();
        check_eq("t1_rd_en", 64'(ram_en), 64'd1);
        check_eq("t1_rd_we", 64'(ram_we), 64'd0);
        cyc(); smp();
        check_eq("t1_rd_capture_en", 64'(ram_en), 64'd0);
        check_eq("t1_rd_done_early", 64'(jtag_done), 64'd0);
        cyc(); smp();
        check_eq("t1_rd_done", 64'(jtag_done), 64'd1);
        check_eq("t1_rd_data", 64'(jtag_rdata), 64'hDEADBEEF);

        // T6: Avalon write then read from idle
        cyc(); av_write = 1'b1; av_address = 8'h03; av_writedata = 32'h12345678;
        smp(); check_eq("t6_wr_wait0", 64'(av_waitrequest), 64'd1);
        cyc(); smp();
        check_eq("t6_wr_wait1", 64'(av_waitrequest), 64'd0);
        check_eq("t6_wr_we", 64'(ram_we), 64'd1);
        check_eq("t6_wr_addr", 64'(ram_addr), 64'h03);
        cyc(); av_write = 1'b0; av_read = 1'b1;
        smp(); check_eq("t6_rd_wait0", 64'(av_waitrequest), 64'd1);
        cyc(); smp(); check_eq("t6_rd_wait1", 64'(av_waitrequest), 64'd1);
        cyc(); smp();
        check_eq("t6_rd_wait2", 64'(av_waitrequest), 64'd0);
        check_eq("t6_rd_data", 64'(av_readdata), 64'h12345678);
        cyc(); av_read = 1'b0;
        smp(); check_eq("t6_idle_wait", 64'(av_waitrequest), 64'd0);

        // T2: simultaneous JTAG read and Avalon read after reset
        cyc(); reset_n = 1'b0;
        cyc(); reset_n = 1'b1;
        cyc(); jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10; av_read = 1'b1; av_address = 8'h03;
        lowk = -1; jdk = -1;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (k == 1) check_eq("t2_first_grant", 64'(ram_addr), 64'h10);
            if (jtag_done) jdk = k;
            if (!av_waitrequest) begin
                lowk = k;
                check_eq("t2_av_data", 64'(av_readdata), 64'h12345678);
                break;
            end
            cyc(); jtag_req = 1'b0;
        end
        check_eq("t2_av_latency", 64'(lowk), 64'd5);
        check_eq("t2_jtag_done_cyc", 64'(jdk), 64'd3);
        check_eq("t2_jtag_rdata", 64'(jtag_rdata), 64'hDEADBEEF);
        cyc(); av_read = 1'b0; jtag_req = 1'b0;

        // T3: both sides continuously requesting writes
        n_acc = 0; prev_src = -1; b2b = 0; j_idx = 0; a_idx = 0; prev_en = 1'b0; timeout = 1'b1;
        cyc();
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h20; jtag_wdata = 32'hA000_0000;
        av_write = 1'b1; av_address = 8'h40; av_writedata = 32'hB000_0000;
        for (int k = 0; k < 80; k++) begin
            smp();
            if (ram_en && prev_en) b2b++;
            prev_en = ram_en;
            if (ram_en) begin
                src = (ram_addr >= 8'h40) ? 1 : 0;
                if (prev_src >= 0) check_eq("t3_alternate", 64'(src), 64'(1 - prev_src));
                prev_src = src;
                n_acc++;
            end
            rearm  = jtag_done && (n_acc < 10);
            av_adv = av_write && !av_waitrequest;
            if (n_acc >= 10) timeout = 1'b0;
            cyc();
            jtag_req = rearm;
            if (rearm) begin
                j_idx++;
                jtag_addr = 8'(8'h20 + j_idx);
            end
            if (av_adv) begin
                if (n_acc >= 10) av_write = 1'b0;
                else begin
                    a_idx++;
                    av_address = 8'(8'h40 + a_idx);
                end
            end
            if (!timeout) break;
        end
        check_eq("t3_ten_accesses", 64'(timeout), 64'd0);
        check_eq("t3_no_back_to_back", 64'(b2b), 64'd0);
        jtag_req = 1'b0; av_write = 1'b0;
        for (int k = 0; k < 6; k++) cyc();

        // T4: overrun behaviour
        check_eq("t4_ovr_init", 64'(jtag_overrun), 64'd0);
        d0 = done_cnt; w0 = wr_cnt;
        jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10; smp();
        cyc(); jtag_wr = 1'b1; jtag_addr = 8'h55; jtag_wdata = 32'h1;
        smp(); check_eq("t4_ovr_not_yet", 64'(jtag_overrun), 64'd0);
        cyc(); jtag_req = 1'b0;
        smp(); check_eq("t4_ovr_set", 64'(jtag_overrun), 64'd1);
        for (int k = 0; k < 6; k++) cyc();
        check_eq("t4_single_done", 64'(done_cnt - d0), 64'd1);
        check_eq("t4_dropped_write", 64'(wr_cnt - w0), 64'd0);
        overrun_clr = 1'b1;
        cyc(); overrun_clr = 1'b0;
        smp(); check_eq("t4_ovr_clr", 64'(jtag_overrun), 64'd0);
        cyc(); jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10;
        cyc(); overrun_clr = 1'b1;
        cyc(); jtag_req = 1'b0; overrun_clr = 1'b0;
        smp(); check_eq("t4_set_wins", 64'(jtag_overrun), 64'd1);
        for (int k = 0; k < 4; k++) cyc();
        overrun_clr = 1'b1;
        cyc(); overrun_clr = 1'b0;
        cyc();
        d0 = done_cnt;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h66; jtag_wdata = 32'hA5;
        cyc(); jtag_wr = 1'b0;
        cyc(); jtag_req = 1'b0;
        smp(); check_eq("t4_completion_capture", 64'(jtag_overrun), 64'd0);
        for (int k = 0; k < 5; k++) cyc();
        check_eq("t4_two_done", 64'(done_cnt - d0), 64'd2);
        check_eq("t4_rdata", 64'(jtag_rdata), 64'hA5);

        // T5: reset during ACCESS of a JTAG read
        cyc(); jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10; smp();
        cyc(); jtag_req = 1'b0;
        smp(); check_eq("t5_in_access", 64'(ram_en), 64'd1);
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        check_eq("t5_en_async", 64'(ram_en), 64'd0);
        check_eq("t5_rdata_cleared", 64'(jtag_rdata), 64'd0);
        cyc(); cyc(); reset_n = 1'b1;
        e0 = en_cnt;
        for (int k = 0; k < 6; k++) cyc();
        check_eq("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t5_idle_after", 64'(en_cnt - e0), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
